// File: rtl/piso_serializer_if.sv
// Load handshake bundle for piso_serializer: valid/ready with a WIDTH-bit word.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding the pattern detector, one bit per clk.
// Optional macro PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  piso_serializer_if.slave  bus,
  output logic              dout,
  output logic              dout_active,
  output logic              frame_done
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned    CNT_W    = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] PREV_CNT = CNT_W'(FRAME_LEN - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    SHIFT = 2'b10
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;

  logic             last_c;
  logic             accept_c;
  logic             first_bit_c;
  logic             shift_bit_c;
  logic             next_bit_c;
  logic [WIDTH-1:0] load_rest_c;
  logic [WIDTH-1:0] shift_rest_c;

  // Ready only while idle or while the last frame bit is on dout.
  assign last_c         = (state == SHIFT) && (cnt == LAST_CNT);
  assign bus.load_ready = (state == IDLE) || last_c;
  assign accept_c       = bus.load_valid && bus.load_ready;

  // shreg holds the bits not yet presented, aligned so the next one sits at the send end.
  always_comb begin
    first_bit_c  = 1'b0;
    shift_bit_c  = 1'b0;
    load_rest_c  = '0;
    shift_rest_c = '0;
    if (MSB_FIRST) begin
      first_bit_c  = bus.load_data[WIDTH-1];
      load_rest_c  = bus.load_data << 1;
      shift_bit_c  = shreg[WIDTH-1];
      shift_rest_c = shreg << 1;
    end else begin
      first_bit_c  = bus.load_data[0];
      load_rest_c  = bus.load_data >> 1;
      shift_bit_c  = shreg[0];
      shift_rest_c = shreg >> 1;
    end
  end

`ifdef PISO_PARITY_EN
  logic parity_q;
  assign next_bit_c = (cnt == CNT_W'(WIDTH - 1)) ? parity_q : shift_bit_c;
`else
  assign next_bit_c = shift_bit_c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      dout        <= IDLE_BIT;
      dout_active <= 1'b0;
      frame_done  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, SHIFT: begin
          if (accept_c) begin
            state       <= SHIFT;
            cnt         <= '0;
            shreg       <= load_rest_c;
            dout        <= first_bit_c;
            dout_active <= 1'b1;
            frame_done  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q    <= ^bus.load_data;
`endif
          end else if ((state == SHIFT) && !last_c) begin
            cnt         <= cnt + CNT_W'(1);
            shreg       <= shift_rest_c;
            dout        <= next_bit_c;
            dout_active <= 1'b1;
            frame_done  <= (cnt == PREV_CNT);
          end else begin
            state       <= IDLE;
            cnt         <= '0;
            dout        <= IDLE_BIT;
            dout_active <= 1'b0;
            frame_done  <= 1'b0;
          end
        end
        default: begin
          // Corrupted encoding: abandon whatever was in flight.
          state       <= IDLE;
          cnt         <= '0;
          dout        <= IDLE_BIT;
          dout_active <= 1'b0;
          frame_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share one load stream;
// expected bits are queued at acceptance and popped as each frame bit appears.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lv = 1'b0;
  logic [7:0] ld = 8'h00;

  logic m_dout, m_act, m_done;
  logic l_dout, l_act, l_done;

  int checks = 0;
  int errors = 0;
  bit accepted;
  bit qm[$];
  bit ql[$];

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) bm ();
  piso_serializer_if #(.WIDTH(8)) bl ();

  assign bm.load_valid = lv;
  assign bm.load_data  = ld;
  assign bl.load_valid = lv;
  assign bl.load_data  = ld;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(bm.slave),
    .dout(m_dout), .dout_active(m_act), .frame_done(m_done)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(bl.slave),
    .dout(l_dout), .dout_active(l_act), .frame_done(l_done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Compare one lane against its queue; returns the ready level the bench expects.
  task automatic check_lane(input int lane, input logic act, input logic o,
                            input logic fd, input logic rdy, output logic exp_rdy);
    string pre;
    int    n;
    bit    e;
    pre = (lane == 0) ? "msb" : "lsb";
    n   = (lane == 0) ? qm.size() : ql.size();
    chk({pre, "_active"}, act, n > 0);
    if (n > 0) begin
      if (lane == 0) e = qm.pop_front();
      else           e = ql.pop_front();
      exp_rdy = (n == 1);
      chk({pre, "_dout"}, o, e);
      chk({pre, "_frame_done"}, fd, n == 1);
    end else begin
      exp_rdy = 1'b1;
      chk({pre, "_dout_idle"}, o, 1'b1);
      chk({pre, "_frame_done_idle"}, fd, 1'b0);
    end
    chk({pre, "_load_ready"}, rdy, exp_rdy);
  endtask

  task automatic push_word(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) qm.push_back(d[i]);
    for (int i = 0; i <= 7; i++) ql.push_back(d[i]);
`ifdef PISO_PARITY_EN
    qm.push_back(^d);
    ql.push_back(^d);
`endif
  endtask

  // One clock: drive inputs, check current outputs, model acceptance, advance.
  task automatic step(input logic v, input logic [7:0] d);
    logic rm, rl;
    lv = v;
    ld = d;
    check_lane(0, m_act, m_dout, m_done, bm.load_ready, rm);
    check_lane(1, l_act, l_dout, l_done, bl.load_ready, rl);
    accepted = 1'b0;
    if (v && rm && rst_n) begin
      push_word(d);
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d);
    accepted = 1'b0;
    for (int k = 0; k < 40 && !accepted; k++) step(1'b1, d);
    if (!accepted) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held for 3 clocks, then quiet idle.
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00);
    rst_n = 1'b1;
    idle(10);

    // Single frame, then idle.
    send_word(8'h55);
    idle(12);

    // Back-to-back with valid held.
    send_word(8'h55);
    send_word(8'hF0);
    idle(14);

    // Single set bit exercises bit ordering on both lanes.
    send_word(8'h01);
    idle(12);

    // Reset in the middle of a frame.
    send_word(8'hAA);
    idle(3);
    lv = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_msb_dout", m_dout, 1'b1);
    chk("rst_mid_msb_active", m_act, 1'b0);
    chk("rst_mid_msb_done", m_done, 1'b0);
    chk("rst_mid_msb_ready", bm.load_ready, 1'b1);
    chk("rst_mid_lsb_dout", l_dout, 1'b1);
    chk("rst_mid_lsb_active", l_act, 1'b0);
    qm.delete();
    ql.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    send_word(8'h0F);
    idle(12);

    // Parity-relevant words (odd and even weight).
    send_word(8'h07);
    idle(12);
    send_word(8'h03);
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that feeds the serial pattern detector; produces one bit per clk on dout, which drives the detector's din input directly.
- Accepts WIDTH-bit words through a valid/ready handshake and shifts them out back-to-back with no gap cycles.
- Drives IDLE_BIT on dout between frames. The default IDLE_BIT of 1 keeps the downstream detector parked in its idle state.

Parameters:
- WIDTH, 8, data word width in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 1'b1, level driven on dout when no frame is active.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  word to serialize.
- dout  output  1  serial bit stream; connects to the detector din.
- dout_active  output  1  dout carries a frame bit this cycle.
- frame_done  output  1  dout is presenting the last bit of the current frame.

Behaviour:
- Reset: clk is single clock; rst_n is asynchronous, active-low.
  - While rst_n=0: dout=IDLE_BIT, dout_active=0, frame_done=0, load_ready=1, state=IDLE, bit counter=0, shift register=0.
- Outputs dout, dout_active and frame_done are registered. load_ready is combinational from state and counter only; it never depends on load_valid.
- FSM has two states, IDLE and SHIFT.
  - IDLE: load_ready=1. Acceptance (load_valid&&load_ready at posedge) latches load_data, moves to SHIFT and clears the counter. Otherwise dout stays at IDLE_BIT.
  - SHIFT: one bit per cycle. dout_active=1 for exactly FRAME_LEN consecutive cycles. FRAME_LEN = WIDTH, or WIDTH+1 with parity (see Optional Feature).
  - SHIFT: the counter runs 0..FRAME_LEN-1. frame_done=1 only on the cycle where counter=FRAME_LEN-1.
- Latency: the first bit of an accepted word appears on dout in the cycle after the accepting edge.
- Bit order: MSB_FIRST=1 sends load_data[WIDTH-1] down to [0]; MSB_FIRST=0 sends [0] up to [WIDTH-1].
- Back-to-back:
  - load_ready=1 in SHIFT only during the cycle dout shows the last frame bit (frame_done=1).
  - An acceptance in that cycle reloads the shift register and restarts the counter at 0, staying in SHIFT. dout_active stays 1 with zero idle cycles.
- End of frame: if no acceptance occurs on the last-bit cycle, the next cycle returns to IDLE with dout=IDLE_BIT, dout_active=0, frame_done=0.
- load_valid while load_ready=0 is ignored. The source must hold load_valid and load_data until acceptance; the block does not capture early.
- Reset mid-frame: rst_n low aborts the frame immediately, with no partial completion. dout returns to IDLE_BIT asynchronously. After release, the block is in IDLE with load_ready=1.
- Unknown or illegal state encodings recover to IDLE on the next clk.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra bit equal to the even parity (XOR reduction) of the accepted word is driven with dout_active=1.
  - FRAME_LEN=WIDTH+1. frame_done and the back-to-back load_ready window move to the parity-bit cycle.
- Not defined: no parity bit; FRAME_LEN=WIDTH; no parity logic is synthesized.

Test Plan:
- Reset then idle: rst_n=0 for 3 clks, release, no load for 10 clks -> dout=1, dout_active=0, frame_done=0, load_ready=1 throughout.
- Single frame: WIDTH=8, MSB_FIRST=1, load 8'h55 for one cycle -> from next cycle dout=0,1,0,1,0,1,0,1, dout_active=1 for 8 clks, frame_done only on the 8th bit, then dout=1. The downstream detector flag rises after the frame.
- Back-to-back: hold load_valid with 8'h55 then 8'hF0 -> second accept happens on the frame_done cycle; 16 contiguous active bits 01010101_11110000; load_ready low for cycles 1..7 of each frame.
- LSB-first: MSB_FIRST=0, load 8'h01 -> dout=1,0,0,0,0,0,0,0.
- Reset mid-frame: load 8'hAA, assert rst_n=0 after bit 3 -> dout=1, dout_active=0 asynchronously; after release, load 8'h0F -> clean full frame 00001111 with no residue.
- PISO_PARITY_EN defined:
  - load 8'h07 -> 00000111 then parity bit 1, 9 active clks, frame_done on the 9th.
  - load 8'h03 -> parity bit 0.
